// File: rtl/gb_timer.sv
// -----------------------------------------------------------------------------
// gb_timer : Game Boy DIV / TIMA / TMA / TAC timer unit
//
// Purpose
//   Counts T-cycles delivered by the clock divider (gclk, sampled in the sclk
//   domain) in a free-running system counter. The DIV register is the top
//   byte of that counter. TIMA counts falling edges of a selected counter bit
//   gated by TAC[2]. When TIMA overflows it reads 0x00 for OVF_DELAY ticks,
//   then reloads from TMA and raises a one-cycle interrupt request.
//
// Ports
//   sclk  in   1  system clock, the only clock
//   rst   in   1  asynchronous active-low reset
//   gclk  in   1  divided Game Boy clock, synchronous to sclk (sampled only)
//   addr  in   2  register select: 0=DIV 1=TIMA 2=TMA 3=TAC
//   wr    in   1  single-cycle write strobe
//   din   in   8  write data
//   dout  out  8  registered read data for addr (valid one sclk after addr)
//   irq   out  1  timer interrupt request, one sclk pulse
//
// Configuration
//   TIMER_DIV_GLITCH_EN : when defined, falling edges of the timer signal
//   caused by DIV or TAC writes also increment TIMA (DMG-accurate). When
//   undefined, those write-induced edges are suppressed and only edges
//   caused by tick counting increment TIMA.
// -----------------------------------------------------------------------------
module gb_timer #(
    parameter int DIV_WIDTH = 16,
    parameter int OVF_DELAY = 4
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       gclk,
    input  logic [1:0] addr,
    input  logic       wr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);

    // Width of the post-overflow delay counter; always at least one bit.
    localparam int CNT_W = (OVF_DELAY < 2) ? 1 : $clog2(OVF_DELAY + 1);

    localparam logic [1:0] ADDR_DIV  = 2'd0;
    localparam logic [1:0] ADDR_TIMA = 2'd1;
    localparam logic [1:0] ADDR_TMA  = 2'd2;
    localparam logic [1:0] ADDR_TAC  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVF_DELAY - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DELAY = 1'b1
    } ovf_state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic                 r_gclk_d;
    logic [DIV_WIDTH-1:0] r_sys_cnt;
    logic [7:0]           r_tima;
    logic [7:0]           r_tma;
    logic [2:0]           r_tac;
    logic                 r_tsig_d;
    ovf_state_t           r_state;
    logic [CNT_W-1:0]     r_ovf_cnt;
    logic [7:0]           r_dout;
    logic                 r_irq;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                 w_tick;
    logic                 w_wr_div;
    logic                 w_wr_tima;
    logic                 w_wr_tma;
    logic                 w_wr_tac;
    logic [DIV_WIDTH-1:0] w_sys_cnt_nxt;
    logic [2:0]           w_tac_nxt;
    logic                 w_tsig;
    logic                 w_tsig_post_wr;
    logic                 w_tsig_d_nxt;
    logic                 w_tima_inc;
    logic                 w_reload;
    logic [7:0]           w_rd_data;

    // Select the counter bit that feeds the timer signal for a TAC rate code.
    function automatic logic sel_bit(input logic [DIV_WIDTH-1:0] cnt,
                                     input logic [1:0]           rate);
        logic bit_v;
        case (rate)
            2'b00:   bit_v = cnt[9];
            2'b01:   bit_v = cnt[3];
            2'b10:   bit_v = cnt[5];
            2'b11:   bit_v = cnt[7];
            default: bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

    // Decode writes, tick detection and next system counter / TAC values.
    always_comb begin
        w_tick    = gclk & ~r_gclk_d;
        w_wr_div  = wr & (addr == ADDR_DIV);
        w_wr_tima = wr & (addr == ADDR_TIMA);
        w_wr_tma  = wr & (addr == ADDR_TMA);
        w_wr_tac  = wr & (addr == ADDR_TAC);

        // A DIV write clears the counter and overrides a coincident tick.
        if (w_wr_div) begin
            w_sys_cnt_nxt = '0;
        end else if (w_tick) begin
            w_sys_cnt_nxt = r_sys_cnt + DIV_WIDTH'(1);
        end else begin
            w_sys_cnt_nxt = r_sys_cnt;
        end

        if (w_wr_tac) begin
            w_tac_nxt = din[2:0];
        end else begin
            w_tac_nxt = r_tac;
        end
    end

    // Timer signal, its edge detector input, and the TIMA increment request.
    always_comb begin
        w_tsig = r_tac[2] & sel_bit(r_sys_cnt, r_tac[1:0]);
        // Timer signal as it will look once this cycle's writes have landed.
        w_tsig_post_wr = w_tac_nxt[2] & sel_bit(w_sys_cnt_nxt, w_tac_nxt[1:0]);
`ifdef TIMER_DIV_GLITCH_EN
        // Delayed copy always tracks the live signal, so a write that drops
        // the signal produces a falling edge on the following cycle.
        w_tsig_d_nxt = w_tsig;
        if (w_wr_div | w_wr_tac) begin
            w_tsig_d_nxt = w_tsig;
        end else begin
            w_tsig_d_nxt = w_tsig;
        end
`else
        // On a DIV/TAC write the delayed copy is preloaded with the
        // post-write signal, hiding any edge the write itself would cause.
        if (w_wr_div | w_wr_tac) begin
            w_tsig_d_nxt = w_tsig_post_wr;
        end else begin
            w_tsig_d_nxt = w_tsig;
        end
`endif
        w_tima_inc = r_tsig_d & ~w_tsig;
        // Reload happens on the tick that brings the delay count to OVF_DELAY.
        w_reload   = (r_state == ST_DELAY) & w_tick & (r_ovf_cnt == CNT_LAST);
    end

    // Read data multiplexer; unused TAC bits read as ones.
    always_comb begin
        case (addr)
            ADDR_DIV:  w_rd_data = r_sys_cnt[DIV_WIDTH-1 -: 8];
            ADDR_TIMA: w_rd_data = r_tima;
            ADDR_TMA:  w_rd_data = r_tma;
            ADDR_TAC:  w_rd_data = {5'b11111, r_tac};
            default:   w_rd_data = 8'h00;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential logic
    // -------------------------------------------------------------------------

    // gclk delay stage for rising-edge (tick) detection.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_gclk_d <= 1'b0;
        end else begin
            r_gclk_d <= gclk;
        end
    end

    // System counter (DIV source).
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_sys_cnt <= '0;
        end else begin
            r_sys_cnt <= w_sys_cnt_nxt;
        end
    end

    // TAC register; only the low three bits are stored.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_tac <= 3'b000;
        end else begin
            r_tac <= w_tac_nxt;
        end
    end

    // TMA register; writes take effect immediately.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_tma <= 8'h00;
        end else if (w_wr_tma) begin
            r_tma <= din;
        end else begin
            r_tma <= r_tma;
        end
    end

    // Registered copy of the timer signal for falling-edge detection.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_tsig_d <= 1'b0;
        end else begin
            r_tsig_d <= w_tsig_d_nxt;
        end
    end

    // TIMA counter with overflow FSM, reload delay and interrupt pulse.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_ovf_cnt <= '0;
            r_tima    <= 8'h00;
            r_irq     <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ovf_cnt <= '0;
                    if (w_wr_tima) begin
                        // CPU write wins over a coincident increment.
                        r_tima <= din;
                    end else if (w_tima_inc) begin
                        if (r_tima == 8'hFF) begin
                            r_tima  <= 8'h00;
                            r_state <= ST_DELAY;
                        end else begin
                            r_tima <= r_tima + 8'd1;
                        end
                    end else begin
                        r_tima <= r_tima;
                    end
                end
                ST_DELAY: begin
                    if (w_reload) begin
                        // TMA wins: a same-cycle TMA write is forwarded and
                        // a same-cycle TIMA write is dropped.
                        r_tima    <= w_wr_tma ? din : r_tma;
                        r_irq     <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_ovf_cnt <= '0;
                    end else if (w_wr_tima) begin
                        // Writing TIMA during the delay cancels reload and irq.
                        r_tima    <= din;
                        r_state   <= ST_IDLE;
                        r_ovf_cnt <= '0;
                    end else begin
                        if (w_tima_inc) begin
                            r_tima <= r_tima + 8'd1;
                        end else begin
                            r_tima <= r_tima;
                        end
                        if (w_tick) begin
                            r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
                        end else begin
                            r_ovf_cnt <= r_ovf_cnt;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_ovf_cnt <= '0;
                    r_tima    <= r_tima;
                end
            endcase
        end
    end

    // Registered read port.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_dout <= 8'h00;
        end else begin
            r_dout <= w_rd_data;
        end
    end

    assign dout = r_dout;
    assign irq  = r_irq;

endmodule
